// File: rtl/sub_serial_32_pkg.sv
// Shared types and constants for the serial subtractor: FSM state encoding,
// default operand/slice widths and the slice-count helper.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CHUNK = 8;
    localparam int SLICES        = DEFAULT_WIDTH / DEFAULT_CHUNK;

    function automatic int slice_count(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/sub_serial_32_if.sv
// Operand/result handshake bundle for sub_serial_32. The ovf wire and its
// modport entries exist only when SUB_SIGNED_OVF_EN is defined.
interface sub_serial_32_if import sub_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SUB_SIGNED_OVF_EN
    logic             ovf;

    modport slave (
        input  in_valid, in1, in2, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );

    modport master (
        output in_valid, in1, in2, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );
`else
    modport slave (
        input  in_valid, in1, in2, bin, out_ready,
        output in_ready, out_valid, diff, bout
    );

    modport master (
        output in_valid, in1, in2, bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );
`endif
endinterface

// File: rtl/sub_serial_32_chunk.sv
// Combinational CHUNK-bit subtract with borrow: d = a - b - borrow_in.
module sub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             borrow_in,
    output logic [CHUNK-1:0] d,
    output logic             borrow_out
);

    // One extra bit catches the wrap below zero, which is exactly the borrow.
    logic [CHUNK:0] full;

    assign full       = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, borrow_in};
    assign d          = full[CHUNK-1:0];
    assign borrow_out = full[CHUNK];

endmodule

// File: rtl/sub_serial_32.sv
// Multi-cycle WIDTH-bit subtractor processing one CHUNK-bit slice per clock.
// Define SUB_SIGNED_OVF_EN to add the signed-overflow output.
module sub_serial_32 import sub_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic            clk,
    input  logic            rst,
    sub_serial_32_if.slave  bus
);

    localparam int NSL   = slice_count(WIDTH, CHUNK);
    localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSL - 1);

    state_t           state;
    state_t           next_state;
    logic             in_ready_c;
    logic             out_valid_c;
    logic             accept;
    logic             finish;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_reg;
    logic             bout_reg;
    logic [IDX_W-1:0] idx;

    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK-1:0] d_slice;
    logic             borrow_next;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) next_state = BUSY;
            end
            BUSY: begin
                if (idx == LAST_IDX) next_state = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign accept = bus.in_valid && in_ready_c;
    assign finish = (state == BUSY) && (idx == LAST_IDX);

    // A single slice subtractor is shared across all slices via the index mux.
    assign a_slice = a_reg[idx*CHUNK +: CHUNK];
    assign b_slice = b_reg[idx*CHUNK +: CHUNK];

    sub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a          (a_slice),
        .b          (b_slice),
        .borrow_in  (borrow_reg),
        .d          (d_slice),
        .borrow_out (borrow_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            bout_reg   <= 1'b0;
            idx        <= '0;
        end else if (accept) begin
            a_reg      <= bus.in1;
            b_reg      <= bus.in2;
            borrow_reg <= bus.bin;
            idx        <= '0;
        end else if (state == BUSY) begin
            diff_reg[idx*CHUNK +: CHUNK] <= d_slice;
            borrow_reg <= borrow_next;
            idx        <= finish ? '0 : idx + 1'b1;
            if (finish) bout_reg <= borrow_next;
        end
    end

`ifdef SUB_SIGNED_OVF_EN
    logic ovf_reg;

    // The top slice of the result is d_slice on the finishing cycle.
    always_ff @(posedge clk) begin
        if (rst)
            ovf_reg <= 1'b0;
        else if (finish)
            ovf_reg <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                       (d_slice[CHUNK-1] != a_reg[WIDTH-1]);
    end

    assign bus.ovf = ovf_reg;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.diff      = diff_reg;
    assign bus.bout      = bout_reg;

endmodule

// File: tb/tb_sub_serial_32.sv
// Self-checking bench for sub_serial_32: vector table, stall/reset sequences
// and random operations, with expected results queued on accept.
module tb_sub_serial_32;
    import sub_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    typedef struct {
        logic [W-1:0] in1;
        logic [W-1:0] in2;
        logic         bin;
        logic [W-1:0] exp_diff;
        logic         exp_bout;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    sub_serial_32_if #(.WIDTH(W)) bus ();

    sub_serial_32 #(.WIDTH(W), .CHUNK(DEFAULT_CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference built on the add-with-inverted-operands identity.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        exp_t m;
        logic [W:0] s;
        s      = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ~bi};
        m.diff = s[W-1:0];
        m.bout = ~s[W];
        m.ovf  = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        return m;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic bi, input exp_t e);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in1      = a;
        bus.in2      = b;
        bus.bin      = bi;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in1      = '1;
        bus.in2      = '1;
        bus.bin      = 1'b1;
        sb.push_back(e);
    endtask

    task automatic compare_result(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_sb: got result, expected none queued", name);
            return;
        end
        e = sb.pop_front();
        check({name, "_diff"}, bus.diff, e.diff);
        check({name, "_bout"}, {31'b0, bus.bout}, {31'b0, e.bout});
`ifdef SUB_SIGNED_OVF_EN
        check({name, "_ovf"}, {31'b0, bus.ovf}, {31'b0, e.ovf});
`endif
    endtask

    // Called right after the accepting edge; measures latency then handshakes.
    task automatic check_output(input string name);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.out_valid || n >= 20) break;
            @(posedge clk);
            n++;
        end
        check({name, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
        if (!bus.out_valid) return;
        check({name, "_latency"}, n, SLICES);
        check({name, "_busy_ready"}, {31'b0, bus.in_ready}, 32'd0);
        compare_result(name);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check({name, "_post_valid"}, {31'b0, bus.out_valid}, 32'd0);
        check({name, "_post_ready"}, {31'b0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[7];
        exp_t e;
        logic [W-1:0] ra, rb;
        logic         rbin;

        vecs[0] = '{32'd5,        32'd3,        1'b0, 32'h0000_0002, 1'b0};
        vecs[1] = '{32'd0,        32'd1,        1'b0, 32'hFFFF_FFFF, 1'b1};
        vecs[2] = '{32'h0100_0000, 32'h0,       1'b1, 32'h00FF_FFFF, 1'b0};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
        vecs[4] = '{32'h8000_0000, 32'd1,       1'b0, 32'h7FFF_FFFF, 1'b0};
        vecs[5] = '{32'd0,        32'd0,        1'b1, 32'hFFFF_FFFF, 1'b1};
        vecs[6] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready",  {31'b0, bus.in_ready},  32'd1);
        check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("reset_diff",      bus.diff,               32'd0);
        check("reset_bout",      {31'b0, bus.bout},      32'd0);
`ifdef SUB_SIGNED_OVF_EN
        check("reset_ovf",       {31'b0, bus.ovf},       32'd0);
`endif

        $display("[TB] vector table");
        for (int i = 0; i < 7; i++) begin
            e      = model(vecs[i].in1, vecs[i].in2, vecs[i].bin);
            e.diff = vecs[i].exp_diff;
            e.bout = vecs[i].exp_bout;
            apply_stimulus(vecs[i].in1, vecs[i].in2, vecs[i].bin, e);
            check_output($sformatf("vec%0d", i));
        end

`ifdef SUB_SIGNED_OVF_EN
        $display("[TB] signed overflow corner");
        e = '{32'h7FFF_FFFF, 1'b0, 1'b1};
        apply_stimulus(32'h8000_0000, 32'd1, 1'b0, e);
        check_output("ovf_corner");
`endif

        $display("[TB] stalled result with pending operands");
        e = '{32'hCC79_6877, 1'b0, 1'b0};
        apply_stimulus(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, e);
        repeat (SLICES) @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in1      = 32'h0000_0010;
        bus.in2      = 32'h0000_0020;
        bus.bin      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", {31'b0, bus.out_valid}, 32'd1);
            check("stall_ready", {31'b0, bus.in_ready},  32'd0);
            check("stall_diff",  bus.diff,               32'hCC79_6877);
            check("stall_bout",  {31'b0, bus.bout},      32'd0);
            @(negedge clk);
        end
        compare_result("stall");
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        check("stall_release_ready", {31'b0, bus.in_ready},  32'd1);
        check("stall_release_valid", {31'b0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        e = '{32'hFFFF_FFEF, 1'b1, 1'b0};
        sb.push_back(e);
        check_output("stall_second");

        $display("[TB] reset during busy");
        apply_stimulus(32'h1111_1111, 32'h0101_0101, 1'b0, model(32'h1111_1111, 32'h0101_0101, 1'b0));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        check("rst_busy_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_busy_diff",  bus.diff,               32'd0);
        check("rst_busy_ready", {31'b0, bus.in_ready},  32'd1);
        check("rst_busy_bout",  {31'b0, bus.bout},      32'd0);
        e = '{32'd0, 1'b0, 1'b0};
        apply_stimulus(32'd7, 32'd7, 1'b0, e);
        check_output("after_rst");

        $display("[TB] random operations");
        for (int i = 0; i < 1000; i++) begin
            ra   = $urandom;
            rb   = (i % 8 == 0) ? ra : $urandom;
            rbin = 1'($urandom_range(0, 1));
            apply_stimulus(ra, rb, rbin, model(ra, rb, rbin));
            check_output("rand");
        end

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d left, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
